// File: rtl/mux_3.sv
// 3:1 datapath mux with an illegal-select flag, a sticky registered error and an optional registered output.
// Define MUX3_REG_OUT_EN to register y_q; otherwise y_q is a combinational copy of y.
module mux_3 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] y,
   output logic             sel_err,
   output logic [WIDTH-1:0] y_q,
   output logic             err_q
);

   logic [WIDTH-1:0] w_y;
   logic             w_sel_err;
   logic             r_err;

   // An unknown select propagates X instead of quietly picking d0.
   always_comb begin
      w_y = '0;
      case (sel)
         2'b00:   w_y = d0;
         2'b01:   w_y = d1;
         2'b10:   w_y = d2;
         2'b11:   w_y = '0;
         default: w_y = 'x;
      endcase
   end

   assign w_sel_err = (sel == 2'b11);

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_err <= 1'b0;
      else if (w_sel_err)
         r_err <= 1'b1;
   end

`ifdef MUX3_REG_OUT_EN
   logic [WIDTH-1:0] r_y_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_y_q <= '0;
      else
         r_y_q <= w_y;
   end

   assign y_q = r_y_q;
`else
   assign y_q = w_y;
`endif

   assign y       = w_y;
   assign sel_err = w_sel_err;
   assign err_q   = r_err;

endmodule

// File: tb/tb_mux_3.sv
// Directed self-checking bench for mux_3 (WIDTH=8 main instance, WIDTH=1 boundary instance).
`timescale 1ns/1ps
module tb_mux_3;

   logic       clk;
   logic       rst_n;
   logic [7:0] d0, d1, d2;
   logic [1:0] sel;
   logic [7:0] y, y_q;
   logic       sel_err, err_q;

   logic       n_d0, n_d1, n_d2;
   logic       n_y, n_y_q, n_sel_err, n_err_q;

   int tests_run;
   int tests_failed;

   mux_3 #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .d2(d2), .sel(sel),
      .y(y), .sel_err(sel_err), .y_q(y_q), .err_q(err_q)
   );

   mux_3 #(.WIDTH(1)) dut_w1 (
      .clk(clk), .rst_n(rst_n), .d0(n_d0), .d1(n_d1), .d2(n_d2), .sel(sel),
      .y(n_y), .sel_err(n_sel_err), .y_q(n_y_q), .err_q(n_err_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      // Reset wins over a simultaneous illegal select.
      @(negedge clk);
      rst_n = 1'b0;
      sel   = 2'b11;
      @(posedge clk); #1;
      tests_run++;
      if (err_q !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_err_q: got %b expected 0", err_q);
      end
      tests_run++;
      if (y !== 8'h00 || sel_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_comb: y=%h sel_err=%b expected y=00 sel_err=1", y, sel_err);
      end
`ifdef MUX3_REG_OUT_EN
      tests_run++;
      if (y_q !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_y_q: got %h expected 00", y_q);
      end
`endif
   endtask

   task automatic test_select();
      logic [7:0] exp_y [3];
      exp_y[0] = 8'h03;
      exp_y[1] = 8'h0c;
      exp_y[2] = 8'h30;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sel = 2'(i);
         #10;
         tests_run++;
         if (y !== exp_y[i] || sel_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL select_%0d: y=%h sel_err=%b expected y=%h sel_err=0", i, y, sel_err, exp_y[i]);
         end
`ifndef MUX3_REG_OUT_EN
         tests_run++;
         if (y_q !== exp_y[i]) begin
            tests_failed++;
            $display("FAIL select_%0d_y_q: got %h expected %h", i, y_q, exp_y[i]);
         end
`endif
      end
   endtask

   task automatic test_err_sticky();
      @(negedge clk);
      rst_n = 1'b1;
      sel   = 2'b11;
      #1;
      tests_run++;
      if (y !== 8'h00 || sel_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL illegal_comb: y=%h sel_err=%b expected y=00 sel_err=1", y, sel_err);
      end
      tests_run++;
      if (err_q !== 1'b0) begin
         tests_failed++;
         $display("FAIL err_before_edge: got %b expected 0", err_q);
      end
      @(posedge clk); #1;
      tests_run++;
      if (err_q !== 1'b1) begin
         tests_failed++;
         $display("FAIL err_set: got %b expected 1", err_q);
      end
      @(negedge clk);
      sel = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (err_q !== 1'b1 || sel_err !== 1'b0 || y !== 8'h03) begin
         tests_failed++;
         $display("FAIL err_sticky: err_q=%b sel_err=%b y=%h expected err_q=1 sel_err=0 y=03", err_q, sel_err, y);
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (err_q !== 1'b0) begin
         tests_failed++;
         $display("FAIL err_clear: got %b expected 0", err_q);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

`ifdef MUX3_REG_OUT_EN
   task automatic test_reg_out();
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (y_q !== 8'h00) begin
         tests_failed++;
         $display("FAIL regout_reset: got %h expected 00", y_q);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sel   = 2'b10;
      #1;
      tests_run++;
      if (y !== 8'h30 || y_q !== 8'h00) begin
         tests_failed++;
         $display("FAIL regout_latency: y=%h y_q=%h expected y=30 y_q=00", y, y_q);
      end
      @(posedge clk); #1;
      tests_run++;
      if (y_q !== 8'h30) begin
         tests_failed++;
         $display("FAIL regout_load: got %h expected 30", y_q);
      end
      @(negedge clk);
      sel = 2'b01;
      @(posedge clk); #1;
      tests_run++;
      if (y_q !== 8'h0c) begin
         tests_failed++;
         $display("FAIL regout_b2b: got %h expected 0c", y_q);
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (y_q !== 8'h00) begin
         tests_failed++;
         $display("FAIL regout_midreset: got %h expected 00", y_q);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (y_q !== 8'h0c) begin
         tests_failed++;
         $display("FAIL regout_reload: got %h expected 0c", y_q);
      end
   endtask
`else
   task automatic test_pass_through();
      @(negedge clk);
      rst_n = 1'b0;
      sel   = 2'b01;
      #1;
      tests_run++;
      if (y_q !== 8'h0c) begin
         tests_failed++;
         $display("FAIL passthru_in_reset: got %h expected 0c", y_q);
      end
      sel = 2'b10;
      #1;
      tests_run++;
      if (y_q !== 8'h30 || y !== 8'h30) begin
         tests_failed++;
         $display("FAIL passthru_follow: y=%h y_q=%h expected 30", y, y_q);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask
`endif

   task automatic test_width1();
      logic exp_n [4];
      exp_n[0] = 1'b1;
      exp_n[1] = 1'b0;
      exp_n[2] = 1'b1;
      exp_n[3] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sel = 2'(i);
         #1;
         tests_run++;
         if (n_y !== exp_n[i] || n_sel_err !== (i == 3)) begin
            tests_failed++;
            $display("FAIL width1_sel%0d: y=%b sel_err=%b expected y=%b sel_err=%b", i, n_y, n_sel_err, exp_n[i], (i == 3));
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n = 1'b0;
      sel   = 2'b00;
      d0 = 8'h03;
      d1 = 8'h0c;
      d2 = 8'h30;
      n_d0 = 1'b1;
      n_d1 = 1'b0;
      n_d2 = 1'b1;

      test_reset();
      test_select();
      test_err_sticky();
`ifdef MUX3_REG_OUT_EN
      test_reg_out();
`else
      test_pass_through();
`endif
      test_width1();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
